mem_bus_controller_32: RTL and testbench
========================================

MEM_BUS_CONTROLLER_32 -- requirements
Module: mem_bus_controller_32

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: CPU/external address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, multiple of 8; lanes NB = DATA_WIDTH/8.
REQ-003 SHALL have parameter INT_ADDR_BITS, default 16: internal RAM = 2^INT_ADDR_BITS bytes, mapped at address 0.
REQ-004 SHALL have parameter EXT_TIMEOUT, default 255: maximum external wait cycles, range 1..65535.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all state changes on its rising edge; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have these CPU-side ports:
 - cpu_req  in  1  request, held with stable address/data until cpu_ready
 - cpu_we  in  1  1 = write, 0 = read
 - cpu_addr  in  ADDR_WIDTH  byte address
 - cpu_wdata  in  DATA_WIDTH  write data
 - cpu_be  in  NB  write byte enables
 - cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ready
 - cpu_ready  out  1  one-cycle completion pulse
 - cpu_err  out  1  bus error, qualified by cpu_ready
REQ-007 SHALL have these external and status ports:
 - ext_addr  out  ADDR_WIDTH  external address
 - ext_wdata  out  DATA_WIDTH  external write data
 - ext_rdata  in  DATA_WIDTH  external read data
 - ext_be  out  NB  external byte enables
 - ext_read  out  1  external read strobe
 - ext_write  out  1  external write strobe
 - ext_ready  in  1  external completion
 - busy  out  1  high in any state except IDLE

Function
REQ-008 SHALL implement FSM IDLE, INT, EXT, DONE; busy = (state != IDLE).
REQ-009 IDLE with cpu_req=1 SHALL latch addr/we/wdata/be and go to INT if cpu_addr < 2^INT_ADDR_BITS (upper bits zero), else EXT.
REQ-010 INT SHALL access word cpu_addr[INT_ADDR_BITS-1:log2(NB)]; low address bits ignored (no misalignment fault); INT -> DONE unconditionally.
REQ-011 Internal write SHALL update only lanes with be=1; be=0 completes with no change; reads return the full word.
REQ-012 Internal latency: request sampled at edge N, cpu_ready high in cycle N+2 (IDLE->INT->DONE).
REQ-013 EXT SHALL drive ext_read = !we or ext_write = we, plus ext_addr/ext_wdata/ext_be from latched values; strobes held until ext_ready sampled high; strobes low in every other state.
REQ-014 On ext_ready=1 in EXT: capture ext_rdata (reads), go to DONE; ext_ready outside EXT SHALL be ignored.
REQ-015 DONE SHALL assert cpu_ready for exactly one cycle with cpu_rdata = captured data (all zeros for writes), then go to IDLE.
REQ-016 cpu_req high in IDLE after DONE SHALL be treated as a new request; peak throughput one internal access per 3 cycles.
REQ-017 cpu_req changes while busy SHALL be ignored; operation uses latched values.

Reset
REQ-018 rst=1 at a rising edge SHALL force IDLE and clear cpu_ready, cpu_err, cpu_rdata, ext_read, ext_write, ext_addr, ext_wdata, ext_be, busy and the timeout counter to 0.
REQ-019 Reset mid-operation SHALL abort: strobes low, no cpu_ready for the aborted request, pending internal write discarded; RAM contents not reset.

Configuration
REQ-020 With MEMCTRL_EXT_TIMEOUT_EN defined: counter clears on EXT entry and increments each EXT cycle without ext_ready; if EXT_TIMEOUT cycles elapse, drop strobes, go to DONE with cpu_err=1, cpu_rdata=0; ext_ready in the final counted cycle wins over timeout.
REQ-021 Without MEMCTRL_EXT_TIMEOUT_EN: EXT waits indefinitely, cpu_err tied 0, no counter.

Verification
REQ-022 Write 0x0000_0010 data 0xDEADBEEF be=0xF, then read -> read cpu_ready 2 cycles after request, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-023 Write 0x0000_0010 data 0x11223344 be=0x2 over 0xDEADBEEF, read -> 0xDEAD33EF.
REQ-024 Read 0x0001_0000, ext_ready after 5 cycles with ext_rdata=0xCAFEF00D -> ext_read high exactly 5 cycles, cpu_rdata=0xCAFEF00D, cpu_ready one cycle later.
REQ-025 MEMCTRL_EXT_TIMEOUT_EN, EXT_TIMEOUT=4, read 0x8000_0000, ext_ready never -> strobe drops after 4 cycles, cpu_ready=1, cpu_err=1, cpu_rdata=0; without macro busy stays high.
REQ-026 rst=1 for 1 cycle during external write wait -> ext_write low next cycle, busy=0, no cpu_ready; subsequent internal read of 0x0 returns pre-reset value.

Source files
------------

// File: rtl/mem_bus_controller_32.sv
// mem_bus_controller_32: CPU bus bridge to an internal byte-lane RAM at address 0 or to an external bus
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata/be : CPU request. The request is latched in IDLE.
//   cpu_rdata/ready/err      : one-cycle completion pulse with read data and error flag
//   ext_addr/wdata/be/read/write : external bus request. It is held while in EXT.
//   ext_rdata/ready  : external response
//   busy             : high whenever the FSM is not in IDLE
//
// Optional feature: define MEMCTRL_EXT_TIMEOUT_EN to bound external waits to EXT_TIMEOUT cycles.
// A timed-out access completes with cpu_err=1.
module mem_bus_controller_32 #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INT_ADDR_BITS = 16,
    parameter int EXT_TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_ready,
    output logic                    cpu_err,
    output logic [ADDR_WIDTH-1:0]   ext_addr,
    output logic [DATA_WIDTH-1:0]   ext_wdata,
    input  logic [DATA_WIDTH-1:0]   ext_rdata,
    output logic [DATA_WIDTH/8-1:0] ext_be,
    output logic                    ext_read,
    output logic                    ext_write,
    input  logic                    ext_ready,
    output logic                    busy
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int WORDS = 2 ** (INT_ADDR_BITS - LB);

    typedef enum logic [1:0] {IDLE, INT, EXT, DONE} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           be_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    is_int;
    logic                    timeout;
    logic [DATA_WIDTH-1:0]   mem [WORDS];

    // The internal window requires every address bit above the RAM size to be zero.
    assign is_int = cpu_addr[ADDR_WIDTH-1:INT_ADDR_BITS] == '0;

`ifdef MEMCTRL_EXT_TIMEOUT_EN
    logic [15:0] cnt;
    logic        err_q;
    // The timeout fires in the last counted cycle unless ext_ready arrives in that same cycle.
    assign timeout = state == EXT && !ext_ready && cnt == 16'(EXT_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE) cnt <= '0;
            else if (state == EXT && !ext_ready) cnt <= cnt + 16'd1;
            if (state == IDLE && cpu_req) err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n   = (state == IDLE) ? (cpu_req ? (is_int ? INT : EXT) : IDLE) :
                    (state == INT)  ? DONE :
                    (state == EXT)  ? ((ext_ready || timeout) ? DONE : EXT) : IDLE;
        busy      = state != IDLE;
        cpu_ready = state == DONE;
        cpu_rdata = cpu_ready ? rdata_q : '0;
        ext_read  = state == EXT && !we_q;
        ext_write = state == EXT && we_q;
        ext_addr  = addr_q;
        ext_wdata = wdata_q;
        ext_be    = be_q;
`ifdef MEMCTRL_EXT_TIMEOUT_EN
        cpu_err   = cpu_ready && err_q;
`else
        cpu_err   = 1'b0;
`endif
    end

    // Request latch and read-data capture. Write completions and timeouts leave rdata_q at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
                be_q    <= cpu_be;
                rdata_q <= '0;
            end
            if (state == INT) rdata_q <= we_q ? '0 : mem[addr_q[INT_ADDR_BITS-1:LB]];
            if (state == EXT && ext_ready) rdata_q <= we_q ? '0 : ext_rdata;
        end
    end

    // The RAM is never cleared. A reset in the INT cycle discards the pending write.
    always_ff @(posedge clk) begin
        if (!rst && state == INT && we_q)
            for (int i = 0; i < NB; i++)
                if (be_q[i]) mem[addr_q[INT_ADDR_BITS-1:LB]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_mem_bus_controller_32.sv
// tb_mem_bus_controller_32: directed self-checking bench for mem_bus_controller_32
module tb_mem_bus_controller_32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic [31:0] ext_addr, ext_wdata;
    logic [31:0] ext_rdata = '0;
    logic [3:0]  ext_be;
    logic        ext_read, ext_write;
    logic        ext_ready = 1'b0;
    logic        busy;
    int          vectors = 0, miscompares = 0;

    mem_bus_controller_32 #(.EXT_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_err(cpu_err), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .ext_be(ext_be), .ext_read(ext_read), .ext_write(ext_write), .ext_ready(ext_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and waits a bounded number of cycles for cpu_ready.
    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic [31:0] rd,
                          output logic err);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        lat = 0; rd = 'x; err = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_ready) begin
                lat = i; rd = cpu_rdata; err = cpu_err;
                break;
            end
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({busy, cpu_ready, cpu_err, ext_read, ext_write} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=00000", {busy, cpu_ready, cpu_err, ext_read, ext_write});
        end
        vectors++;
        if ({cpu_rdata, ext_addr, ext_wdata, ext_be} !== '0) begin
            miscompares++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%h want all 0", cpu_rdata, ext_addr, ext_wdata, ext_be);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_internal();
        int lat; logic [31:0] rd; logic err;
        bus_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, err);
        vectors++;
        if (lat !== 2 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL int_write lat=%0d rdata=%h want lat=2 rdata=0", lat, rd);
        end
        bus_op(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
        vectors++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
            miscompares++;
            $display("FAIL int_read lat=%0d rdata=%h err=%b want 2 deadbeef 0", lat, rd, err);
        end
        bus_op(1'b1, 32'h10, 32'h11223344, 4'h2, lat, rd, err);
        bus_op(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
        vectors++;
        if (rd !== 32'hDEAD33EF) begin
            miscompares++;
            $display("FAIL lane_write rdata=%h want deadbeef->dead33ef", rd);
        end
        bus_op(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, rd, err);
        bus_op(1'b0, 32'h13, 32'h0, 4'h0, lat, rd, err);
        vectors++;
        if (lat !== 2 || rd !== 32'hDEAD33EF) begin
            miscompares++;
            $display("FAIL be0_unaligned lat=%0d rdata=%h want 2 dead33ef", lat, rd);
        end
    endtask

    task automatic test_latched();
        int lat; logic [31:0] rd; logic err;
        bus_op(1'b1, 32'h20, 32'h01020304, 4'hF, lat, rd, err);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h0BADF00D; cpu_be = 4'hF;
        tick();
        vectors++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEAD33EF) begin
            miscompares++;
            $display("FAIL latched_read ready=%b rdata=%h want 1 dead33ef", cpu_ready, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        bus_op(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err);
        vectors++;
        if (rd !== 32'h01020304) begin
            miscompares++;
            $display("FAIL latched_nowrite rdata=%h want 01020304", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat = '0;
        logic [31:0] d1 = '0, d2 = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat[i] = cpu_ready;
            if (i == 1) d1 = cpu_rdata;
            if (i == 4) d2 = cpu_rdata;
        end
        cpu_req = 1'b0;
        tick(); tick();
        vectors++;
        if (pat !== 6'b010010) begin
            miscompares++;
            $display("FAIL b2b_pattern ready=%b want 010010 (cycle1 at lsb)", pat);
        end
        vectors++;
        if (d1 !== 32'hDEAD33EF || d2 !== 32'hDEAD33EF) begin
            miscompares++;
            $display("FAIL b2b_data got=%h,%h want dead33ef", d1, d2);
        end
    endtask

    task automatic test_external();
        int n = 0;
        logic a_ok;
        ext_ready = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_ready_idle busy=%b ready=%b want 0 0", busy, cpu_ready);
        end
        ext_ready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0000; cpu_be = 4'hF;
        tick();
        a_ok = ext_addr === 32'h0001_0000 && ext_write === 1'b0;
        while (ext_read === 1'b1 && n < 20) begin
            n++;
            if (n == 5) begin ext_ready = 1'b1; ext_rdata = 32'hCAFEF00D; end
            tick();
        end
        ext_ready = 1'b0; ext_rdata = '0;
        vectors++;
        if (n !== 5 || !a_ok) begin
            miscompares++;
            $display("FAIL ext_strobe cycles=%0d addr_ok=%b want 5 1", n, a_ok);
        end
        vectors++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hCAFEF00D || cpu_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_read ready=%b rdata=%h err=%b want 1 cafef00d 0", cpu_ready, cpu_rdata, cpu_err);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0000;
        tick();
`ifdef MEMCTRL_EXT_TIMEOUT_EN
        while (ext_read === 1'b1 && n < 20) begin n++; tick(); end
        vectors++;
        if (n !== 4 || cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout cycles=%0d ready=%b err=%b rdata=%h want 4 1 1 0", n, cpu_ready, cpu_err, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
`else
        while (ext_read === 1'b1 && n < 20) begin n++; tick(); end
        vectors++;
        if (n !== 20 || busy !== 1'b1 || cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout cycles=%0d busy=%b ready=%b err=%b want 20 1 0 0", n, busy, cpu_ready, cpu_err);
        end
        cpu_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ext_read !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout_reset busy=%b ext_read=%b want 0 0", busy, ext_read);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic err;
        int seen = 0;
        bus_op(1'b1, 32'h0, 32'hA5A55A5A, 4'hF, lat, rd, err);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0001_0000; cpu_wdata = 32'h12345678; cpu_be = 4'h5;
        tick();
        vectors++;
        if (ext_write !== 1'b1 || ext_read !== 1'b0 || ext_wdata !== 32'h12345678 || ext_be !== 4'h5) begin
            miscompares++;
            $display("FAIL ext_write_drive wr=%b rd=%b wdata=%h be=%h want 1 0 12345678 5", ext_write, ext_read, ext_wdata, ext_be);
        end
        tick(); tick();
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        vectors++;
        if (ext_write !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_abort wr=%b busy=%b ready=%b want 0 0 0", ext_write, busy, cpu_ready);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'hFFFFFFFF; cpu_be = 4'hF;
        tick();
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ready === 1'b1) seen++;
            tick();
        end
        vectors++;
        if (seen !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL int_abort ready_pulses=%0d busy=%b want 0 0", seen, busy);
        end
        bus_op(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, err);
        vectors++;
        if (lat !== 2 || rd !== 32'hA5A55A5A) begin
            miscompares++;
            $display("FAIL post_reset_read lat=%0d rdata=%h want 2 a5a55a5a", lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_internal();
        test_latched();
        test_back_to_back();
        test_external();
        test_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
